// File: rtl/alu_ctrl_dmem.sv
// Single-cycle MIPS execute/memory slice: main decoder, 32-bit ALU and a
// 256 x 32 data memory with asynchronous read and clocked write.
module alu_ctrl_dmem (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        reg_dst,
    output logic        jump,
    output logic        branch,
    output logic        branch_ne,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [2:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] mem_read_data,
    output logic [31:0] write_data
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [31:0] sign_ext;
    logic [31:0] operand_b;
    logic [7:0]  mem_index;
    logic [31:0] mem [256];

    always_comb begin
        reg_dst     = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        mem_read    = 1'b0;
        mem_to_reg  = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        alu_control = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_NOR:  alu_control = ALU_NOR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: reg_write   = 1'b0;
                endcase
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch      = 1'b1;
                alu_control = ALU_SUB;
            end
            OP_BNE: begin
                branch_ne   = 1'b1;
                alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_ANDI: begin
                alu_src     = 1'b1;
                reg_write   = 1'b1;
                alu_control = ALU_AND;
            end
            OP_ORI: begin
                alu_src     = 1'b1;
                reg_write   = 1'b1;
                alu_control = ALU_OR;
            end
            OP_SLTI: begin
                alu_src     = 1'b1;
                reg_write   = 1'b1;
                alu_control = ALU_SLT;
            end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    // andi/ori also take the sign-extended immediate, unlike real MIPS.
    assign sign_ext  = {{16{imm[15]}}, imm};
    assign operand_b = alu_src ? sign_ext : rt_data;

    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            ALU_AND: alu_result = rs_data & operand_b;
            ALU_OR:  alu_result = rs_data | operand_b;
            ALU_ADD: alu_result = rs_data + operand_b;
            ALU_SUB: alu_result = rs_data - operand_b;
            ALU_SLT: alu_result = ($signed(rs_data) < $signed(operand_b)) ? 32'd1 : 32'd0;
            ALU_NOR: alu_result = ~(rs_data | operand_b);
            default: alu_result = 32'h0;
        endcase
    end

    assign zero = (alu_result == 32'h0);

    // Byte address; upper bits are dropped so the array aliases every 1 KiB.
    assign mem_index = alu_result[9:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_write) begin
            mem[mem_index] <= rt_data;
        end
    end

    assign mem_read_data = mem_read ? mem[mem_index] : 32'h0;
    assign write_data    = mem_to_reg ? mem_read_data : alu_result;

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Directed bench for alu_ctrl_dmem: decode/ALU vector table plus memory
// write, aliasing and reset sequences.
module tb_alu_ctrl_dmem;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reg_dst, jump, branch, branch_ne, mem_read, mem_to_reg;
    logic        mem_write, alu_src, reg_write;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_read_data;
    logic [31:0] write_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_ctrl_dmem dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .imm(imm),
        .rs_data(rs_data), .rt_data(rt_data), .reg_dst(reg_dst), .jump(jump),
        .branch(branch), .branch_ne(branch_ne), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .alu_control(alu_control), .alu_result(alu_result),
        .zero(zero), .mem_read_data(mem_read_data), .write_data(write_data)
    );

    // ctrl order: reg_dst jump branch branch_ne mem_read mem_to_reg mem_write alu_src reg_write
    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] im;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [8:0]  ctrl;
        logic [2:0]  aluc;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] ctrl_now();
        return {reg_dst, jump, branch, branch_ne, mem_read, mem_to_reg,
                mem_write, alu_src, reg_write};
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                         input logic [31:0] rs, input logic [31:0] rt);
        opcode = op; funct = fn; imm = im; rs_data = rs; rt_data = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{"lw_reset",  6'b100011, 6'd0,      16'h0010, 32'h0,        32'h0,        9'b000011011, 3'b010, 32'h10,       1'b0});
        vecs.push_back('{"sub_eq",    6'b000000, 6'b100010, 16'h0,    32'd5,        32'd5,        9'b100000001, 3'b110, 32'h0,        1'b1});
        vecs.push_back('{"slt_neg",   6'b000000, 6'b101010, 16'h0,    32'hFFFFFFFF, 32'd1,        9'b100000001, 3'b111, 32'h1,        1'b0});
        vecs.push_back('{"add",       6'b000000, 6'b100000, 16'h0,    32'd7,        32'd8,        9'b100000001, 3'b010, 32'd15,       1'b0});
        vecs.push_back('{"add_wrap",  6'b000000, 6'b100000, 16'h0,    32'hFFFFFFFF, 32'd2,        9'b100000001, 3'b010, 32'd1,        1'b0});
        vecs.push_back('{"and",       6'b000000, 6'b100100, 16'h0,    32'hF0F0,     32'hFF00,     9'b100000001, 3'b000, 32'hF000,     1'b0});
        vecs.push_back('{"or",        6'b000000, 6'b100101, 16'h0,    32'h0F0,      32'h00F,      9'b100000001, 3'b001, 32'h0FF,      1'b0});
        vecs.push_back('{"nor",       6'b000000, 6'b100111, 16'h0,    32'h0,        32'h0,        9'b100000001, 3'b011, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"bad_funct", 6'b000000, 6'b000000, 16'h0,    32'd1,        32'd2,        9'b100000000, 3'b010, 32'd3,        1'b0});
        vecs.push_back('{"beq",       6'b000100, 6'd0,      16'h0,    32'd3,        32'd4,        9'b001000000, 3'b110, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"bne",       6'b000101, 6'd0,      16'h0,    32'd3,        32'd4,        9'b000100000, 3'b110, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"j",         6'b000010, 6'd0,      16'h0,    32'd1,        32'd2,        9'b010000000, 3'b010, 32'd3,        1'b0});
        vecs.push_back('{"addi",      6'b001000, 6'd0,      16'hFFFF, 32'h10,       32'h0,        9'b000000011, 3'b010, 32'h0F,       1'b0});
        vecs.push_back('{"ori",       6'b001101, 6'd0,      16'h8001, 32'h0,        32'h0,        9'b000000011, 3'b001, 32'hFFFF8001, 1'b0});
        vecs.push_back('{"andi",      6'b001100, 6'd0,      16'h8001, 32'hFFFFFFFF, 32'h0,        9'b000000011, 3'b000, 32'hFFFF8001, 1'b0});
        vecs.push_back('{"slti",      6'b001010, 6'd0,      16'hFFFF, 32'd5,        32'h0,        9'b000000011, 3'b111, 32'h0,        1'b1});
        vecs.push_back('{"sw_addr",   6'b101011, 6'd0,      16'h0004, 32'h100,      32'h55,       9'b000000110, 3'b010, 32'h104,      1'b0});
        vecs.push_back('{"bad_op",    6'b111111, 6'd0,      16'h0,    32'd1,        32'd2,        9'b000000000, 3'b010, 32'd3,        1'b0});

        reset = 1'b1;
        drive(6'b111111, 6'd0, 16'h0, 32'h0, 32'h0);
        tick();
        tick();

        // Table runs with reset held: memory stays cleared, so lw reads 0.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].im, vecs[i].rs, vecs[i].rt);
            tick();
            check32({vecs[i].name, "_ctrl"}, {23'd0, ctrl_now()}, {23'd0, vecs[i].ctrl});
            check32({vecs[i].name, "_aluc"}, {29'd0, alu_control}, {29'd0, vecs[i].aluc});
            check32({vecs[i].name, "_res"}, alu_result, vecs[i].res);
            check32({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].z});
            check32({vecs[i].name, "_wd"}, write_data, vecs[i].ctrl[3] ? 32'h0 : vecs[i].res);
        end
        reset = 1'b0;

        // Not written until the edge: lw before the edge still sees 0.
        drive(6'b101011, 6'd0, 16'h0004, 32'h100, 32'hDEADBEEF);
        #2;
        check32("sw_no_read", mem_read_data, 32'h0);
        drive(6'b100011, 6'd0, 16'h0004, 32'h100, 32'h0);
        #1;
        check32("pre_edge_old", mem_read_data, 32'h0);
        drive(6'b101011, 6'd0, 16'h0004, 32'h100, 32'hDEADBEEF);
        tick();
        drive(6'b100011, 6'd0, 16'h0004, 32'h100, 32'h0);
        #1;
        check32("lw_after_sw", mem_read_data, 32'hDEADBEEF);
        check32("lw_wd", write_data, 32'hDEADBEEF);
        drive(6'b100011, 6'd0, 16'h0007, 32'h500, 32'h0);
        #1;
        check32("lw_alias_507", mem_read_data, 32'hDEADBEEF);
        check32("alias_addr", alu_result, 32'h507);

        drive(6'b101011, 6'd0, 16'h0020, 32'h0, 32'h12345678);
        tick();
        drive(6'b101011, 6'd0, 16'h0004, 32'h100, 32'h11111111);
        tick();
        drive(6'b100011, 6'd0, 16'h0020, 32'h0, 32'h0);
        #1;
        check32("lw_0x20", mem_read_data, 32'h12345678);
        drive(6'b100011, 6'd0, 16'h0004, 32'h100, 32'h0);
        #1;
        check32("lw_overwrite", mem_read_data, 32'h11111111);
        drive(6'b000000, 6'b100000, 16'h0, 32'h104, 32'h0);
        #1;
        check32("rtype_no_mem", mem_read_data, 32'h0);

        // Reset edge with a pending store: store suppressed, everything cleared.
        drive(6'b101011, 6'd0, 16'h0004, 32'h100, 32'h22222222);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(6'b100011, 6'd0, 16'h0004, 32'h100, 32'h0);
        #1;
        check32("rst_word", mem_read_data, 32'h0);
        drive(6'b100011, 6'd0, 16'h0020, 32'h0, 32'h0);
        #1;
        check32("rst_other", mem_read_data, 32'h0);
        tick();
        check32("rst_still0", mem_read_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_dmem.md
# alu_ctrl_dmem

Single-cycle MIPS execute/memory slice: main decoder, 32-bit ALU and a 256-word data memory in one block. The datapath's register file and PC logic drive the instruction fields and register operands in; the block returns all control strobes, the ALU result/zero flag and the write-back value. Everything is combinational except the data-memory array.

## Interface
- No parameters; memory depth is fixed at 256 x 32-bit words.
- clk  in  1  single clock; memory writes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- imm  in  16  instruction[15:0]
- rs_data  in  32  register read port 1 (ALU operand A)
- rt_data  in  32  register read port 2 (ALU operand B when alu_src=0; store data)
- reg_dst, jump, branch, branch_ne, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  decoded control strobes
- alu_control  out  3  ALU operation select
- alu_result  out  32  ALU result (also memory byte address)
- zero  out  1  high when alu_result == 0
- mem_read_data  out  32  memory read data
- write_data  out  32  write-back value: mem_to_reg ? mem_read_data : alu_result

## Operation
- sign_ext = {16{imm[15]}, imm}; operand B = alu_src ? sign_ext : rt_data. Immediates are sign-extended for every opcode, including andi/ori.
- ALU codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed compare, result 1 or 0), 011 NOR; unused codes (100, 101) give 0. ADD/SUB wrap modulo 2^32, no overflow flag.
- Decode (strobes not listed are 0):
  - 000000 R-type: reg_dst, reg_write; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT. Unknown funct: reg_write=0, alu_control=ADD.
  - 100011 lw: alu_src, mem_read, mem_to_reg, reg_write; ADD.
  - 101011 sw: alu_src, mem_write; ADD.
  - 000100 beq: branch; SUB. 000101 bne: branch_ne; SUB.
  - 001000 addi: alu_src, reg_write; ADD. 001100 andi: AND. 001101 ori: OR. 001010 slti: SLT (all with alu_src, reg_write).
  - 000010 j: jump; alu_control ADD.
  - Any other opcode: all strobes 0, alu_control ADD.
- Memory: word index = alu_result[9:2]; bits [1:0] ignored; bits [31:10] ignored (address wraps every 1 KiB).
- Read: mem_read_data = mem[index] when mem_read=1, else 32'h0.
- Write: on rising clk with mem_write=1 and reset=0, mem[index] <= rt_data.
- Reset: on rising clk with reset=1, every memory word cleared to 0; writes suppressed that cycle.

## Timing
- Decoder, ALU, zero, operand mux, write_data: purely combinational, same cycle, independent of reset.
- Memory read asynchronous: lw data valid in the same cycle as its address.
- Write latency 1 edge: data visible to reads after the rising edge that stores it; a same-cycle read of the word being written returns the old contents.
- After a reset edge, any mem_read returns 0 until written.
- reset asserted mid-sequence: stored data lost at that edge; combinational outputs unaffected.

## Test plan
- Reset, then lw opcode with rs_data=0, imm=0x0010 -> mem_read=1, mem_to_reg=1, alu_result=0x10, mem_read_data=0, write_data=0.
- sw rt_data=0xDEADBEEF, rs_data=0x100, imm=0x0004, one clock; then lw same address -> mem_read_data=0xDEADBEEF; address 0x507 (index 0x41, wrapped) also reads it; same-cycle read during the write returns the old value.
- R-type SUB rs=5, rt=5 -> alu_control=110, alu_result=0, zero=1, reg_dst=1; SLT rs=0xFFFFFFFF, rt=1 -> result 1.
- beq opcode rs=3, rt=4 -> branch=1, zero=0; bne same operands -> branch_ne=1, zero=0; j -> jump=1, reg_write=0, mem_write=0.
- addi rs=0x10, imm=0xFFFF -> alu_src=1, alu_result=0x0F; ori rs=0, imm=0x8001 -> 0xFFFF8001.
- Write word, assert reset one edge with mem_write=1 -> that word and all others read 0; unknown opcode 111111 -> all strobes 0.
